// File: rtl/button_debouncer.sv
// Debounces one synchronized button level and emits single-cycle press, release
// and auto-repeat events plus the debounced pressed level.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d_sync,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_C);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    REPEATING,
    RELEASE_CHK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          raw;

  assign raw = ACTIVE_LOW ? ~d_sync : d_sync;

  // Input bounces take priority over timer expiry in every state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        RELEASED: begin
          level <= 1'b0;
          if (raw) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!raw) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= HELD;
            cnt   <= '0;
            press <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!raw) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state        <= REPEATING;
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REPEATING: begin
          if (!raw) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE_CHK: begin
          // A short release glitch falls back to HELD and restarts the hold timer.
          if (raw) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= RELEASED;
            cnt           <= '0;
            release_pulse <= 1'b1;
            level         <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: an active-high and an active-low instance see the same
// button (inverted input), so both must produce identical event streams.
module tb_button_debouncer;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 3;

  localparam logic [1:0] K_PRESS = 2'd1;
  localparam logic [1:0] K_REL   = 2'd2;
  localparam logic [1:0] K_REP   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        lvl;
    logic [31:0] cyc;
  } ev_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  logic d     = 1'b0;
  logic d_low;
  assign d_low = ~d;

  logic lvl0, pr0, rl0, rp0;
  logic lvl1, pr1, rl1, rp1;

  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         q0[$];
  ev_t         q1[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) edge_n <= edge_n + 1;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)
  ) u_hi (
    .Clk(Clk), .Reset(Reset), .d_sync(d),
    .level(lvl0), .press(pr0), .release_pulse(rl0), .repeat_pulse(rp0)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
  ) u_lo (
    .Clk(Clk), .Reset(Reset), .d_sync(d_low),
    .level(lvl1), .press(pr1), .release_pulse(rl1), .repeat_pulse(rp1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input int unsigned c, input logic l);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.lvl  = l;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic mon(input int id, input logic p, input logic r, input logic t, input logic l);
    logic [1:0] k;
    ev_t        e;
    int         qs;
    if (!(p | r | t)) return;
    check($sformatf("dut%0d onehot", id), 32'($countones({p, r, t})), 32'd1);
    k  = p ? K_PRESS : (r ? K_REL : K_REP);
    qs = (id == 0) ? q0.size() : q1.size();
    if (qs == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected_pulse: kind %0d at edge %0d, expected none", id, k, edge_n);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    check($sformatf("dut%0d kind@%0d", id, e.cyc), 32'(k), 32'(e.kind));
    check($sformatf("dut%0d edge kind%0d", id, e.kind), edge_n, e.cyc);
    check($sformatf("dut%0d level kind%0d", id, e.kind), 32'(l), 32'(e.lvl));
  endtask

  // Monitor: every pulse seen is matched against the next expected event.
  always @(negedge Clk) begin
    if (!Reset) begin
      mon(0, pr0, rl0, rp0, lvl0);
      mon(1, pr1, rl1, rp1, lvl1);
    end
  end

  // Called on a falling edge; each of the next n rising edges samples v.
  task automatic hold(input logic v, input int n);
    repeat (n) begin
      d = v;
      @(negedge Clk);
    end
  endtask

  int unsigned e0, p0, e1, e2, e3;

  initial begin
    repeat (2) @(negedge Clk);
    #1;
    check("reset_outputs_hi", 32'({lvl0, pr0, rl0, rp0}), 32'd0);
    check("reset_outputs_lo", 32'({lvl1, pr1, rl1, rp1}), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Bounce: never more than three consecutive high samples.
    for (int i = 0; i < 10; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 1);
    end
    check("bounce_level_hi", 32'(lvl0), 32'd0);
    check("bounce_level_lo", 32'(lvl1), 32'd0);

    // Clean press: five high samples.
    e0 = edge_n;
    expect_ev(K_PRESS, e0 + 5, 1'b1);
    hold(1'b1, 5);
    check("press_level_hi", 32'(lvl0), 32'd1);
    check("press_level_lo", 32'(lvl1), 32'd1);

    // Auto-repeat at +10 then every 3 edges.
    p0 = edge_n;
    for (int k = 0; k < 7; k++) expect_ev(K_REP, p0 + 10 + 3 * k, 1'b1);
    hold(1'b1, 30);

    // Two-cycle release glitch returns to HELD.
    e1 = edge_n;
    hold(1'b0, 2);
    check("glitch_level_hi", 32'(lvl0), 32'd1);
    check("glitch_level_lo", 32'(lvl1), 32'd1);
    expect_ev(K_REP, e1 + 13, 1'b1);
    expect_ev(K_REP, e1 + 16, 1'b1);
    hold(1'b1, 14);

    // Real release.
    e2 = edge_n;
    expect_ev(K_REL, e2 + 5, 1'b0);
    hold(1'b0, 6);
    check("release_level_hi", 32'(lvl0), 32'd0);
    check("release_level_lo", 32'(lvl1), 32'd0);

    // Press into REPEATING, then reset asynchronously while held.
    e0 = edge_n;
    expect_ev(K_PRESS, e0 + 5, 1'b1);
    expect_ev(K_REP, e0 + 15, 1'b1);
    hold(1'b1, 17);
    check("pre_reset_level", 32'(lvl0), 32'd1);
    Reset = 1'b1;
    #1;
    check("async_reset_hi", 32'({lvl0, pr0, rl0, rp0}), 32'd0);
    check("async_reset_lo", 32'({lvl1, pr1, rl1, rp1}), 32'd0);
    hold(1'b1, 2);
    Reset = 1'b0;

    // Still held after reset: treated as a fresh press.
    e3 = edge_n;
    expect_ev(K_PRESS, e3 + 5, 1'b1);
    hold(1'b1, 5);
    expect_ev(K_REL, e3 + 10, 1'b0);
    hold(1'b0, 8);

    check("pending_events_hi", 32'(q0.size()), 32'd0);
    check("pending_events_lo", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
